ascon_seq_ctrl: RTL

ASCON_SEQ_CTRL -- requirements
Module: ascon_seq_ctrl

---
 rtl/ascon_seq_ctrl_pkg.sv | 34 +++
 rtl/ascon_watchdog.sv | 27 ++
 rtl/ascon_seq_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ascon_seq_ctrl_pkg.sv
// Shared types and constants for the Ascon message sequencer.
package ascon_seq_ctrl_pkg;

    localparam int unsigned C_TIMEOUT_DEF = 255;
    localparam int unsigned C_NB_PT_MAX   = 15;
    localparam int unsigned C_BLK_W       = 128;
    localparam int unsigned C_NB_W        = 4;
    localparam int unsigned C_STATE_W     = 4;

    typedef enum logic [C_STATE_W-1:0] {
        ST_IDLE    = 4'd0,
        ST_START   = 4'd1,
        ST_W_INIT  = 4'd2,
        ST_SEND_AD = 4'd3,
        ST_W_DA    = 4'd4,
        ST_SEND_PT = 4'd5,
        ST_W_PT    = 4'd6,
        ST_W_FINAL = 4'd7,
        ST_TAG     = 4'd8,
        ST_ERR     = 4'd9
    } type_ctrl_state;

    // Key and nonce latched at command acceptance
    typedef struct packed {
        logic [C_BLK_W-1:0] key;
        logic [C_BLK_W-1:0] nonce;
    } type_cmd;

    // States in which the watchdog guards a pending core event
    function automatic logic is_wait_state(input type_ctrl_state s);
        return (s == ST_W_INIT) || (s == ST_W_DA) || (s == ST_W_PT) || (s == ST_W_FINAL);
    endfunction

endpackage

// File: rtl/ascon_watchdog.sv
// Loadable down-counter; tc_c flags that the loaded budget is used up.
module ascon_watchdog #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             tc_c
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign tc_c = (cnt_q == '0);

endmodule

// File: rtl/ascon_seq_ctrl.sv
// Sequences one Ascon message through an external core: init, AD, plaintext
// blocks with a one-entry cipher buffer, then the tag, guarded by a watchdog.
module ascon_seq_ctrl
    import ascon_seq_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT   = C_TIMEOUT_DEF,
    parameter int unsigned NB_PT_MAX = C_NB_PT_MAX
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [C_BLK_W-1:0] cmd_key_i,
    input  logic [C_BLK_W-1:0] cmd_nonce_i,
    input  logic [C_NB_W-1:0]  cmd_nb_pt_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [C_BLK_W-1:0] in_data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [C_BLK_W-1:0] out_data_o,
    output logic               tag_valid_o,
    output logic [C_BLK_W-1:0] tag_o,
    input  logic               tag_ready_i,
    output logic               err_o,
    output logic               core_start_o,
    output logic               core_data_valid_o,
    output logic [C_BLK_W-1:0] core_data_o,
    output logic [C_BLK_W-1:0] core_key_o,
    output logic [C_BLK_W-1:0] core_nonce_o,
    input  logic               core_end_init_i,
    input  logic               core_end_da_i,
    input  logic               core_end_tc_i,
    input  logic               core_end_final_i,
    input  logic               core_end_i,
    input  logic               core_cipher_valid_i,
    input  logic [C_BLK_W-1:0] core_cipher_i,
    input  logic [C_BLK_W-1:0] core_tag_i
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    type_ctrl_state     state_q, state_d;
    type_cmd            cmd_q;
    logic [C_NB_W-1:0]  rem_q, rem_d;
    logic               buf_full_q, buf_full_d;
    logic [C_BLK_W-1:0] buf_data_q, tag_q, core_data_q;
    logic               err_q, cmd_ready_q, in_ready_q, tag_valid_q;
    logic               core_start_q, core_dv_q;
    logic               cmd_acc_c, cmd_bad_c, in_acc_c, buf_load_c, buf_drain_c;
    logic               tag_load_c, timeout_c, wd_tc_c, wd_load_c, wd_en_c;

    assign cmd_acc_c   = cmd_valid_i && cmd_ready_q;
    assign cmd_bad_c   = (cmd_nb_pt_i == '0) || (32'(cmd_nb_pt_i) > NB_PT_MAX);
    assign in_acc_c    = in_valid_i && in_ready_q;
    assign buf_load_c  = (state_q == ST_W_PT) && core_cipher_valid_i;
    assign buf_drain_c = buf_full_q && out_ready_i;
    assign buf_full_d  = buf_load_c || (buf_full_q && !buf_drain_c);
    assign tag_load_c  = (state_q == ST_W_FINAL) && core_end_i;
    assign wd_load_c   = is_wait_state(state_d) && (state_d != state_q);
    assign wd_en_c     = is_wait_state(state_q);

    ascon_watchdog #(.WIDTH(WD_W)) u_watchdog (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .load_i     (wd_load_c),
        .load_val_i (WD_W'(TIMEOUT - 1)),
        .en_i       (wd_en_c),
        .tc_c       (wd_tc_c)
    );

    // Next-state logic; a core event wins over a timeout in the same cycle
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        timeout_c = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_ERR: begin
                if (cmd_acc_c) begin
                    state_d = cmd_bad_c ? ST_ERR : ST_START;
                    rem_d   = cmd_nb_pt_i;
                end
            end
            ST_START: state_d = ST_W_INIT;
            ST_W_INIT: begin
                if (core_end_init_i) state_d = ST_SEND_AD;
                else if (wd_tc_c)    timeout_c = 1'b1;
            end
            ST_SEND_AD: if (in_acc_c) state_d = ST_W_DA;
            ST_W_DA: begin
                if (core_end_da_i) state_d = ST_SEND_PT;
                else if (wd_tc_c)  timeout_c = 1'b1;
            end
            ST_SEND_PT: begin
                if (in_acc_c) begin
                    state_d = ST_W_PT;
                    rem_d   = rem_q - C_NB_W'(1);
                end
            end
            ST_W_PT: begin
                if (core_end_final_i || (core_end_tc_i && (rem_q == '0))) state_d = ST_W_FINAL;
                else if (core_end_tc_i) state_d = ST_SEND_PT;
                else if (wd_tc_c)       timeout_c = 1'b1;
            end
            ST_W_FINAL: begin
                if (core_end_i)   state_d = ST_TAG;
                else if (wd_tc_c) timeout_c = 1'b1;
            end
            ST_TAG: if (tag_ready_i && !buf_full_q) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (timeout_c) state_d = ST_ERR;
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            rem_q        <= '0;
            buf_full_q   <= 1'b0;
            buf_data_q   <= '0;
            tag_q        <= '0;
            core_data_q  <= '0;
            err_q        <= 1'b0;
            cmd_ready_q  <= 1'b1;
            in_ready_q   <= 1'b0;
            tag_valid_q  <= 1'b0;
            core_start_q <= 1'b0;
            core_dv_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            buf_full_q   <= buf_full_d;
            cmd_ready_q  <= (state_d == ST_IDLE) || (state_d == ST_ERR);
            in_ready_q   <= (state_d == ST_SEND_AD) || ((state_d == ST_SEND_PT) && !buf_full_d);
            tag_valid_q  <= (state_d == ST_TAG);
            core_start_q <= (state_d == ST_START);
            core_dv_q    <= in_acc_c;
            if (in_acc_c)   core_data_q <= in_data_i;
            if (buf_load_c) buf_data_q  <= core_cipher_i;
            if (tag_load_c) tag_q       <= core_tag_i;
            if (cmd_acc_c)  cmd_q       <= '{key: cmd_key_i, nonce: cmd_nonce_i};
            if (timeout_c || (cmd_acc_c && cmd_bad_c)) err_q <= 1'b1;
            else if (cmd_acc_c)                        err_q <= 1'b0;
        end
    end

    assign cmd_ready_o       = cmd_ready_q;
    assign in_ready_o        = in_ready_q;
    assign out_valid_o       = buf_full_q;
    assign out_data_o        = buf_data_q;
    assign tag_valid_o       = tag_valid_q;
    assign tag_o             = tag_q;
    assign err_o             = err_q;
    assign core_start_o      = core_start_q;
    assign core_data_valid_o = core_dv_q;
    assign core_data_o       = core_data_q;
    assign core_key_o        = cmd_q.key;
    assign core_nonce_o      = cmd_q.nonce;

endmodule
